fighter_anim_ctrl: RTL and testbench
====================================

// Module: fighter_anim_ctrl
// PURPOSE
//  Per-fighter animation/action controller; sits directly upstream of the sprite renderer.
//  Turns player commands, hit events and HP-zero into the renderer's character_state and frame_num.
//  Also produces the hurt/die/move qualifiers that the renderer uses for position updates.
//  Steps animation frames on the vsync-rate frame_clk and emits a one-cycle attack-hit strobe
//  that drives opponent collision logic.
// PARAMETERS
//  TICKS_PER_FRAME   4   frame_clk rising edges per animation frame step (>=1)
//  N_STAND           8   frames in stand loop
//  N_ATTACK          9   frames in attack (one-shot)
//  N_MOVE            5   frames in move-left/move-right loops
//  N_HURT            4   frames in hurt (one-shot)
//  N_DIE             12  frames in KO (one-shot, holds last)
//  ATTACK_HIT_FRAME  5   attack frame on which attack_hit strobes (< N_ATTACK)
// PORTS
//  Clk              in   1  50 MHz system clock
//  Reset            in   1  synchronous, active-high
//  frame_clk        in   1  ~60 Hz frame strobe (level, Clk domain); rising edge detected internally
//  game_state       in   8  start=0, game=1, gameover=2
//  key_l, key_r     in   1  move-left / move-right command (level)
//  key_atk, key_def in   1  attack / defend command (level)
//  hit_in           in   1  one-Clk pulse: opponent attack landed on this fighter
//  hp_zero          in   1  HP reached zero (level)
//  character_state  out  8  stand=0 attack=1 movel=2 mover=3 hurt=4 defend=5 die=6
//  frame_num        out  8  current frame index within the active animation
//  move_l, move_r   out  1  high while state is movel / mover
//  hurt             out  1  high while state is hurt
//  die              out  1  high while state is die
//  attack_hit       out  1  one-Clk pulse on entry to attack frame ATTACK_HIT_FRAME
// BEHAVIOUR
//  Reset: state=stand, frame_num=0, tick_cnt=0, all 1-bit outputs 0; frame_clk edge register cleared.
//  adv: one-Clk pulse when TICKS_PER_FRAME frame_clk rising edges have been counted; tick_cnt then wraps to 0.
//  Every state change sets frame_num=0 and tick_cnt=0 in the same cycle.
//  game_state != game: state forced to stand, frame 0. Exception: die is kept through gameover.
//  Entering game (edge 0/2->1): forced to stand, frame 0, including from die.
//  Priority, evaluated every Clk in game:
//   1. hp_zero            -> die, immediate, from any state.
//   2. hit_in, not defend -> hurt, immediate; restarts hurt if already in hurt; ignored in die.
//   3. hit_in in defend   -> no state change.
//  Command transitions happen only from stand/movel/mover/defend, evaluated on any Clk:
//   - key_atk          -> attack (wins over key_def).
//   - else key_def     -> defend.
//   - else key_r xor key_l -> mover / movel.
//   - else             -> stand.
//   - key_l & key_r together -> stand.
//   - No re-entry (no frame reset) when the target equals the current state.
//  One-shots (attack, hurt):
//   - Ignore commands until done.
//   - On adv at frame N-1 -> stand, frame 0.
//   - Attack is interruptible only by priorities 1-2.
//  Loops (stand, movel, mover): on adv, frame_num = (frame_num==N-1) ? 0 : frame_num+1.
//  defend: frame_num held at 0.
//  die:
//   - Advances on adv up to N_DIE-1 and holds there.
//   - Left only by Reset or the game-entry edge.
//  attack_hit: asserted the cycle after frame_num becomes ATTACK_HIT_FRAME in attack; never repeats within one attack.
//  Outputs are registered; state/frame are visible 1 Clk after the causing input or adv.
//  All frame arithmetic is 8-bit unsigned; no value >= N of the active animation is ever output.
// STRUCTURE
//  Shared package fighter_pkg:
//   - char_state_t enum {stand, attack, movel, mover, hurt, defend, die}, logic [7:0].
//   - game_state_t enum {start, game, gameover}, logic [7:0].
//   - Frame-count localparams.
//  Sub-module anim_tick_gen: frame_clk edge detect plus TICKS_PER_FRAME counter -> adv pulse; has a clear input.
//  Top: single always_ff for state/frame and a combinational next-state block.
// TESTING
//  1. Reset, game_state=1, idle, TICKS_PER_FRAME=1, 10 frame_clk edges
//     -> state 0; frame_num 0..7,0,1.
//  2. key_r held for 6 adv
//     -> state 3, move_r=1, frame_num 0..4,0.
//     Then key_l & key_r together -> state 0, frame 0.
//  3. key_atk 1-Clk pulse
//     -> state 1 for exactly 9 adv; attack_hit single pulse at frame 5; then state 0.
//  4. hit_in during attack frame 3
//     -> next Clk state 4, hurt=1, frame 0; after 4 adv -> state 0.
//     Same hit_in while key_def held (state 5) -> stays 5.
//  5. hp_zero during movel
//     -> state 6, die=1; frame holds at 11 after 11+ adv; game_state->2 keeps 6.
//     game_state->1 -> state 0, frame 0.
//  6. Reset asserted mid-attack at frame 4
//     -> next Clk state 0, frame 0, all 1-bit outputs 0; no attack_hit.

Source files
------------

// File: rtl/fighter_pkg.sv
// Shared encodings and default animation lengths for the fighter animation controller.
package fighter_pkg;

  typedef enum logic [7:0] {
    CS_STAND  = 8'd0,
    CS_ATTACK = 8'd1,
    CS_MOVEL  = 8'd2,
    CS_MOVER  = 8'd3,
    CS_HURT   = 8'd4,
    CS_DEFEND = 8'd5,
    CS_DIE    = 8'd6
  } char_state_t;

  typedef enum logic [7:0] {
    GS_START    = 8'd0,
    GS_GAME     = 8'd1,
    GS_GAMEOVER = 8'd2
  } game_state_t;

  localparam int TICKS_PER_FRAME  = 4;
  localparam int N_STAND          = 8;
  localparam int N_ATTACK         = 9;
  localparam int N_MOVE           = 5;
  localparam int N_HURT           = 4;
  localparam int N_DIE            = 12;
  localparam int ATTACK_HIT_FRAME = 5;

endpackage

// File: rtl/anim_tick_gen.sv
// Detects frame_clk rising edges and emits adv once every TICKS_PER_FRAME edges.
module anim_tick_gen #(
  parameter int TICKS_PER_FRAME = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_clk,
  input  logic clear,
  output logic adv
);

  localparam int CW = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;

  logic          fc_q;
  logic [CW-1:0] cnt;
  logic          rise;

  assign rise = frame_clk & ~fc_q;
  assign adv  = rise & (cnt == CW'(TICKS_PER_FRAME - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      fc_q <= 1'b0;
      cnt  <= '0;
    end else begin
      fc_q <= frame_clk;
      // A state change restarts the frame period, discarding any edge seen this cycle.
      if (clear || adv) cnt <= '0;
      else if (rise)    cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fighter_anim_ctrl.sv
// Per-fighter action state machine driving renderer state/frame, motion qualifiers
// and the single-cycle attack_hit strobe.
module fighter_anim_ctrl
  import fighter_pkg::*;
#(
  parameter int TICKS_PER_FRAME  = fighter_pkg::TICKS_PER_FRAME,
  parameter int N_STAND          = fighter_pkg::N_STAND,
  parameter int N_ATTACK         = fighter_pkg::N_ATTACK,
  parameter int N_MOVE           = fighter_pkg::N_MOVE,
  parameter int N_HURT           = fighter_pkg::N_HURT,
  parameter int N_DIE            = fighter_pkg::N_DIE,
  parameter int ATTACK_HIT_FRAME = fighter_pkg::ATTACK_HIT_FRAME
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] game_state,
  input  logic       key_l,
  input  logic       key_r,
  input  logic       key_atk,
  input  logic       key_def,
  input  logic       hit_in,
  input  logic       hp_zero,
  output logic [7:0] character_state,
  output logic [7:0] frame_num,
  output logic       move_l,
  output logic       move_r,
  output logic       hurt,
  output logic       die,
  output logic       attack_hit
);

  char_state_t state, nstate, cmd;
  logic [7:0]  nframe, last;
  logic        clr, adv, in_game, in_game_q, hit_done;

  function automatic logic [7:0] anim_len(input char_state_t s);
    case (s)
      CS_STAND:          return 8'(N_STAND);
      CS_ATTACK:         return 8'(N_ATTACK);
      CS_MOVEL, CS_MOVER: return 8'(N_MOVE);
      CS_HURT:           return 8'(N_HURT);
      CS_DIE:            return 8'(N_DIE);
      default:           return 8'd1;
    endcase
  endfunction

  anim_tick_gen #(.TICKS_PER_FRAME(TICKS_PER_FRAME)) u_tick (
    .clk       (Clk),
    .reset     (Reset),
    .frame_clk (frame_clk),
    .clear     (clr),
    .adv       (adv)
  );

  assign in_game         = (game_state == GS_GAME);
  assign character_state = state;

  always_comb begin
    nstate = state;
    nframe = frame_num;
    clr    = 1'b0;
    last   = anim_len(state) - 8'd1;
    cmd    = CS_STAND;
    if (key_atk)              cmd = CS_ATTACK;
    else if (key_def)         cmd = CS_DEFEND;
    else if (key_r ^ key_l)   cmd = key_r ? CS_MOVER : CS_MOVEL;

    if ((!in_game && !(state == CS_DIE && game_state == GS_GAMEOVER)) ||
        (in_game && !in_game_q)) begin
      nstate = CS_STAND;
      nframe = 8'd0;
      clr    = 1'b1;
    end else if (in_game && hp_zero && state != CS_DIE) begin
      nstate = CS_DIE;
      nframe = 8'd0;
      clr    = 1'b1;
    end else if (state == CS_DIE) begin
      if (adv && frame_num < last) nframe = frame_num + 8'd1;
    end else if (hit_in && state != CS_DEFEND) begin
      // Re-hit while hurt restarts the hurt animation from frame 0.
      nstate = CS_HURT;
      nframe = 8'd0;
      clr    = 1'b1;
    end else if (state == CS_ATTACK || state == CS_HURT) begin
      if (adv) begin
        if (frame_num >= last) begin
          nstate = CS_STAND;
          nframe = 8'd0;
          clr    = 1'b1;
        end else begin
          nframe = frame_num + 8'd1;
        end
      end
    end else if (cmd != state) begin
      nstate = cmd;
      nframe = 8'd0;
      clr    = 1'b1;
    end else if (adv && state != CS_DEFEND) begin
      nframe = (frame_num >= last) ? 8'd0 : frame_num + 8'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= CS_STAND;
      frame_num  <= 8'd0;
      in_game_q  <= 1'b0;
      move_l     <= 1'b0;
      move_r     <= 1'b0;
      hurt       <= 1'b0;
      die        <= 1'b0;
      attack_hit <= 1'b0;
      hit_done   <= 1'b0;
    end else begin
      state      <= nstate;
      frame_num  <= nframe;
      in_game_q  <= in_game;
      move_l     <= (nstate == CS_MOVEL);
      move_r     <= (nstate == CS_MOVER);
      hurt       <= (nstate == CS_HURT);
      die        <= (nstate == CS_DIE);
      // hit_done keeps the strobe to one pulse even if the hit frame is held for many cycles.
      attack_hit <= (state == CS_ATTACK) && (frame_num == 8'(ATTACK_HIT_FRAME)) && !hit_done;
      if (state != CS_ATTACK)                        hit_done <= 1'b0;
      else if (frame_num == 8'(ATTACK_HIT_FRAME))    hit_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fighter_anim_ctrl.sv
// Directed scenarios plus randomized run against a rule-level model of the fighter controller.
module tb_fighter_anim_ctrl;

  localparam int TPF = 1;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic [7:0] game_state = 8'd1;
  logic       key_l = 1'b0, key_r = 1'b0, key_atk = 1'b0, key_def = 1'b0;
  logic       hit_in = 1'b0, hp_zero = 1'b0;
  logic [7:0] character_state, frame_num;
  logic       move_l, move_r, hurt, die, attack_hit;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  fighter_anim_ctrl #(.TICKS_PER_FRAME(TPF)) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .frame_clk       (frame_clk),
    .game_state      (game_state),
    .key_l           (key_l),
    .key_r           (key_r),
    .key_atk         (key_atk),
    .key_def         (key_def),
    .hit_in          (hit_in),
    .hp_zero         (hp_zero),
    .character_state (character_state),
    .frame_num       (frame_num),
    .move_l          (move_l),
    .move_r          (move_r),
    .hurt            (hurt),
    .die             (die),
    .attack_hit      (attack_hit)
  );

  // attack_hit pulse monitor
  int         hit_cnt = 0;
  logic [7:0] hit_frame = 8'd0;
  always @(negedge Clk) if (attack_hit === 1'b1) begin hit_cnt++; hit_frame = frame_num; end

  // Rule-level reference model: animation lengths, priorities and frame stepping.
  logic [7:0] m_state = 8'd0, m_frame = 8'd0;
  int         m_ticks = 0;
  logic       m_fcq = 1'b0, m_ing = 1'b0, m_pend = 1'b0, m_hit = 1'b0;

  function automatic int alen(input logic [7:0] s);
    case (s)
      8'd0: return 8;
      8'd1: return 9;
      8'd2, 8'd3: return 5;
      8'd4: return 4;
      8'd6: return 12;
      default: return 1;
    endcase
  endfunction

  always @(posedge Clk) begin : model
    logic [7:0] s, f, tgt;
    int         t;
    logic       adv, chg, pend;
    s = m_state; f = m_frame; t = m_ticks; adv = 1'b0; chg = 1'b0; pend = 1'b0;
    if (frame_clk && !m_fcq) begin
      t = t + 1;
      if (t == TPF) begin adv = 1'b1; t = 0; end
    end
    tgt = key_atk ? 8'd1 : key_def ? 8'd5 : (key_r ^ key_l) ? (key_r ? 8'd3 : 8'd2) : 8'd0;
    if (game_state != 8'd1 && !(s == 8'd6 && game_state == 8'd2)) begin s = 0; f = 0; chg = 1; end
    else if (game_state == 8'd1 && !m_ing)                       begin s = 0; f = 0; chg = 1; end
    else if (game_state == 8'd1 && hp_zero && s != 8'd6)         begin s = 6; f = 0; chg = 1; end
    else if (s == 8'd6) begin if (adv && f < 8'(alen(6) - 1)) f = f + 1; end
    else if (hit_in && s != 8'd5)                                begin s = 4; f = 0; chg = 1; end
    else if (s == 8'd1 || s == 8'd4) begin
      if (adv) begin
        if (int'(f) == alen(s) - 1) begin s = 0; f = 0; chg = 1; end
        else begin f = f + 1; if (s == 8'd1 && f == 8'd5) pend = 1'b1; end
      end
    end
    else if (tgt != s) begin s = tgt; f = 0; chg = 1; end
    else if (adv && s != 8'd5) f = 8'((int'(f) + 1) % alen(s));
    if (chg) t = 0;
    if (Reset) begin
      m_state <= 8'd0; m_frame <= 8'd0; m_ticks <= 0; m_fcq <= 1'b0;
      m_ing <= 1'b0; m_pend <= 1'b0; m_hit <= 1'b0;
    end else begin
      m_state <= s; m_frame <= f; m_ticks <= t; m_fcq <= frame_clk;
      m_ing <= (game_state == 8'd1); m_pend <= pend; m_hit <= m_pend;
    end
  end

  task automatic step();
    @(posedge Clk); @(negedge Clk);
  endtask

  task automatic fc_edge();
    frame_clk = 1'b1; step(); frame_clk = 1'b0; step();
  endtask

  task automatic test_reset();
    Reset = 1'b1; game_state = 8'd1; repeat (3) step();
    n_checks++;
    if ({character_state, frame_num, move_l, move_r, hurt, die, attack_hit} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset: got st=%0d fr=%0d flags=%b%b%b%b%b, want 0 0 00000",
               character_state, frame_num, move_l, move_r, hurt, die, attack_hit);
    end
    Reset = 1'b0; step();
    for (int i = 0; i < 10; i++) begin
      fc_edge();
      n_checks++;
      if (character_state !== 8'd0 || frame_num !== 8'((i + 1) % 8)) begin
        n_fail++;
        $display("FAIL stand_loop[%0d]: got st=%0d fr=%0d, want 0 %0d", i, character_state, frame_num, (i + 1) % 8);
      end
    end
  endtask

  task automatic test_move();
    key_r = 1'b1; step();
    n_checks++;
    if (character_state !== 8'd3 || frame_num !== 8'd0 || move_r !== 1'b1 || move_l !== 1'b0) begin
      n_fail++;
      $display("FAIL mover_entry: got st=%0d fr=%0d mr=%b, want 3 0 1", character_state, frame_num, move_r);
    end
    for (int i = 0; i < 6; i++) begin
      fc_edge();
      n_checks++;
      if (character_state !== 8'd3 || frame_num !== 8'((i + 1) % 5)) begin
        n_fail++;
        $display("FAIL mover_loop[%0d]: got st=%0d fr=%0d, want 3 %0d", i, character_state, frame_num, (i + 1) % 5);
      end
    end
    key_l = 1'b1; step();
    n_checks++;
    if (character_state !== 8'd0 || frame_num !== 8'd0 || move_r !== 1'b0) begin
      n_fail++;
      $display("FAIL both_keys: got st=%0d fr=%0d mr=%b, want 0 0 0", character_state, frame_num, move_r);
    end
    key_l = 1'b0; key_r = 1'b0; step();
  endtask

  task automatic test_attack();
    int h0;
    h0 = hit_cnt;
    key_atk = 1'b1; step(); key_atk = 1'b0;
    n_checks++;
    if (character_state !== 8'd1 || frame_num !== 8'd0) begin
      n_fail++;
      $display("FAIL attack_entry: got st=%0d fr=%0d, want 1 0", character_state, frame_num);
    end
    for (int i = 0; i < 9; i++) begin
      fc_edge();
      n_checks++;
      if (i < 8 && (character_state !== 8'd1 || frame_num !== 8'(i + 1))) begin
        n_fail++;
        $display("FAIL attack_frame[%0d]: got st=%0d fr=%0d, want 1 %0d", i, character_state, frame_num, i + 1);
      end else if (i == 8 && (character_state !== 8'd0 || frame_num !== 8'd0)) begin
        n_fail++;
        $display("FAIL attack_done: got st=%0d fr=%0d, want 0 0", character_state, frame_num);
      end
    end
    n_checks++;
    if (hit_cnt - h0 != 1 || hit_frame !== 8'd5) begin
      n_fail++;
      $display("FAIL attack_hit: got pulses=%0d frame=%0d, want 1 5", hit_cnt - h0, hit_frame);
    end
  endtask

  task automatic test_hurt_defend();
    key_atk = 1'b1; step(); key_atk = 1'b0;
    repeat (3) fc_edge();
    hit_in = 1'b1; step(); hit_in = 1'b0;
    n_checks++;
    if (character_state !== 8'd4 || frame_num !== 8'd0 || hurt !== 1'b1) begin
      n_fail++;
      $display("FAIL hurt_entry: got st=%0d fr=%0d hurt=%b, want 4 0 1", character_state, frame_num, hurt);
    end
    for (int i = 0; i < 4; i++) begin
      fc_edge();
      n_checks++;
      if ((i < 3) ? (character_state !== 8'd4 || frame_num !== 8'(i + 1))
                  : (character_state !== 8'd0 || frame_num !== 8'd0 || hurt !== 1'b0)) begin
        n_fail++;
        $display("FAIL hurt_seq[%0d]: got st=%0d fr=%0d hurt=%b", i, character_state, frame_num, hurt);
      end
    end
    key_def = 1'b1; step();
    hit_in = 1'b1; step(); hit_in = 1'b0; step();
    n_checks++;
    if (character_state !== 8'd5 || frame_num !== 8'd0 || hurt !== 1'b0) begin
      n_fail++;
      $display("FAIL defend_hit: got st=%0d fr=%0d hurt=%b, want 5 0 0", character_state, frame_num, hurt);
    end
    key_def = 1'b0; step();
  endtask

  task automatic test_die();
    key_l = 1'b1; step();
    n_checks++;
    if (character_state !== 8'd2 || move_l !== 1'b1) begin
      n_fail++;
      $display("FAIL movel_entry: got st=%0d ml=%b, want 2 1", character_state, move_l);
    end
    repeat (2) fc_edge();
    hp_zero = 1'b1; step(); hp_zero = 1'b0; key_l = 1'b0;
    n_checks++;
    if (character_state !== 8'd6 || frame_num !== 8'd0 || die !== 1'b1 || move_l !== 1'b0) begin
      n_fail++;
      $display("FAIL die_entry: got st=%0d fr=%0d die=%b, want 6 0 1", character_state, frame_num, die);
    end
    for (int i = 0; i < 14; i++) begin
      fc_edge();
      n_checks++;
      if (character_state !== 8'd6 || frame_num !== 8'((i + 1 > 11) ? 11 : i + 1)) begin
        n_fail++;
        $display("FAIL die_frame[%0d]: got st=%0d fr=%0d, want 6 %0d", i, character_state, frame_num, (i + 1 > 11) ? 11 : i + 1);
      end
    end
    game_state = 8'd2; step(); repeat (2) fc_edge();
    n_checks++;
    if (character_state !== 8'd6 || frame_num !== 8'd11) begin
      n_fail++;
      $display("FAIL die_gameover: got st=%0d fr=%0d, want 6 11", character_state, frame_num);
    end
    game_state = 8'd1; step();
    n_checks++;
    if (character_state !== 8'd0 || frame_num !== 8'd0 || die !== 1'b0) begin
      n_fail++;
      $display("FAIL game_entry: got st=%0d fr=%0d die=%b, want 0 0 0", character_state, frame_num, die);
    end
  endtask

  task automatic test_reset_mid_attack();
    int h0;
    key_atk = 1'b1; step(); key_atk = 1'b0;
    repeat (4) fc_edge();
    n_checks++;
    if (character_state !== 8'd1 || frame_num !== 8'd4) begin
      n_fail++;
      $display("FAIL pre_reset_attack: got st=%0d fr=%0d, want 1 4", character_state, frame_num);
    end
    h0 = hit_cnt;
    Reset = 1'b1; step();
    n_checks++;
    if ({character_state, frame_num, move_l, move_r, hurt, die, attack_hit} !== 21'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got st=%0d fr=%0d flags=%b%b%b%b%b, want 0 0 00000",
               character_state, frame_num, move_l, move_r, hurt, die, attack_hit);
    end
    Reset = 1'b0; step(); repeat (6) fc_edge();
    n_checks++;
    if (hit_cnt != h0 || character_state !== 8'd0) begin
      n_fail++;
      $display("FAIL post_reset_hit: got pulses=%0d st=%0d, want 0 0", hit_cnt - h0, character_state);
    end
  endtask

  task automatic test_random();
    Reset = 1'b1; game_state = 8'd1; step(); Reset = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      Reset     = ($urandom_range(0, 499) == 0);
      frame_clk = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 149) == 0) game_state = 8'($urandom_range(0, 2));
      if ($urandom_range(0, 5) == 0) key_l   = ~key_l;
      if ($urandom_range(0, 5) == 0) key_r   = ~key_r;
      if ($urandom_range(0, 9) == 0) key_atk = ~key_atk;
      if ($urandom_range(0, 7) == 0) key_def = ~key_def;
      hit_in  = ($urandom_range(0, 24) == 0);
      hp_zero = hp_zero ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 299) == 0);
      step();
      n_checks++;
      if (character_state !== m_state || frame_num !== m_frame || attack_hit !== m_hit ||
          {move_l, move_r, hurt, die} !== {m_state == 8'd2, m_state == 8'd3, m_state == 8'd4, m_state == 8'd6}) begin
        n_fail++;
        $display("FAIL random[%0d]: got st=%0d fr=%0d ml/mr/hu/die/ah=%b%b%b%b%b, want st=%0d fr=%0d ah=%b",
                 c, character_state, frame_num, move_l, move_r, hurt, die, attack_hit, m_state, m_frame, m_hit);
      end
    end
  endtask

  initial begin
    test_reset();
    test_move();
    test_attack();
    test_hurt_defend();
    test_die();
    test_reset_mid_attack();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
